mem_access: RTL and testbench
=============================

// Module: mem_access
// PURPOSE
// - MEM pipeline stage: consumes EX/MEM register outputs, performs loads/stores on the data bus, feeds mem_wb.
// - Little-endian byte/half alignment, load sign/zero extension, address-error detection.
// - Stalls the pipeline until the bus acknowledges; a flushed in-flight access is drained.
// PARAMETERS
// - none (widths come from shared package types)
// PORTS
// clk            in   1   clock
// rst            in   1   reset: synchronous, active-high
// flush          in   1   kill current MEM instruction (exception/CP0)
// ex_mem_op      in   4   Mem_op_t: NOP,LB,LBU,LH,LHU,LW,SB,SH,SW
// ex_mem_addr    in   32  effective address
// ex_mem_sdata   in   32  store data (rt)
// ex_wreg_write  in   1   register write enable from EX
// ex_wreg_addr   in   5   destination register
// ex_wreg_data   in   32  ALU result (non-load ops)
// mem_wreg_write out  1   to mem_wb
// mem_wreg_addr  out  5   to mem_wb
// mem_wreg_data  out  32  to mem_wb: load result or ALU result
// stall_req      out  1   freeze PC/IF/ID/EX and ex_mem register
// exc_adel       out  1   load address error
// exc_ades       out  1   store address error
// bad_vaddr      out  32  faulting address (valid with exc_*)
// bus_req        out  1   data bus request
// bus_we         out  1   1 = write
// bus_addr       out  32  word-aligned address {addr[31:2],2'b00}
// bus_be         out  4   byte enables
// bus_wdata      out  32  lane-replicated store data
// bus_rdata      in   32  read data, valid with bus_ack
// bus_ack        in   1   transfer complete (same cycle as req allowed)
// BEHAVIOUR
// - Reset: state IDLE, load_buf 0, bus_req/bus_we 0, bus_be 0, stall_req 0, exc_* 0, mem_wreg_write 0.
// - FSM states: IDLE, WAIT, DONE, DRAIN.
//  IDLE: valid access (op!=NOP, no addr error, !flush) -> bus_req=1, stall_req=1;
//    ack same cycle -> capture, DONE; else WAIT. Non-memory op -> pass-through, no stall.
//  WAIT: hold bus_req/we/addr/be/wdata stable, stall_req=1; ack -> capture, DONE; flush -> DRAIN.
//  DONE: bus_req=0, stall_req=0, output from load_buf; pipeline advances at this edge -> IDLE.
//  DRAIN: bus_req held until ack, stall_req=1, mem_wreg_write=0; ack -> IDLE, data discarded.
// - Min load/store occupancy 2 cycles (IDLE+DONE); each wait cycle adds one.
// - Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0. Violation -> exc_adel (loads)/exc_ades
//   (stores)=1, bad_vaddr=addr, no bus_req, mem_wreg_write=0, no stall; combinational from inputs.
// - Store lanes: SB be=4'b0001<<addr[1:0], wdata={4{sdata[7:0]}}; SH be=addr[1]?1100:0011,
//   wdata={2{sdata[15:0]}}; SW be=1111. Loads: be per same rule, bus_we=0.
// - Load extract: byte lane addr[1:0], half lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
// - Stores force mem_wreg_write=0 regardless of ex_wreg_write.
// - flush in IDLE/DONE: mem_wreg_write=0, no new request; flush ignored in DRAIN.
// - Outputs to mem_wb are valid only when stall_req=0; mem_wb latches unconditionally.
// - rst mid-WAIT: return to IDLE immediately; bus slave also resets on rst (no drain).
// STRUCTURE
// - Shared package: Mem_op_t enum, Word_t/Reg_addr_t/Bit_t, `ENABLE/`DISABLE/`ZERO_WORD/`REG_ZERO,
//   MEM_STATE_t enum.
// - Sub-module mem_align: combinational lane/byte-enable generation and load extract/extension.
// TESTING
// - LW addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF -> stall_req 4 cycles, wdata 0xDEADBEEF, write=1.
// - LB addr 0x103 rdata 0x80FF_0000 -> 0xFFFFFF80; LBU -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
// - SB addr 0x101 sdata 0x12345678, ack same cycle -> be 0010, wdata 0x78787878, write=0, 2 cycles.
// - LW addr 0x102 -> exc_adel=1, bad_vaddr 0x102, bus_req=0, stall_req=0; SH 0x101 -> exc_ades=1.
// - LW in WAIT, flush pulse, ack 2 cycles later -> DRAIN, stall until ack, mem_wreg_write=0.
// - ADD (op NOP, write r3=5) -> pass-through same cycle, stall_req=0, no bus_req.

Source files
------------

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types, constants and op-decode helpers for the MEM stage
package mem_access_pkg;
  typedef logic [31:0] Word_t;
  typedef logic [4:0] Reg_addr_t;
  typedef logic Bit_t;
  localparam Bit_t ENABLE = 1'b1;
  localparam Bit_t DISABLE = 1'b0;
  localparam Word_t ZERO_WORD = 32'h0000_0000;
  localparam Reg_addr_t REG_ZERO = 5'd0;
  typedef enum logic [3:0] {NOP, LB, LBU, LH, LHU, LW, SB, SH, SW} Mem_op_t;
  typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} MEM_STATE_t;
  function automatic Bit_t is_load(Mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW};
  endfunction
  function automatic Bit_t is_store(Mem_op_t op);
    return op inside {SB, SH, SW};
  endfunction
  function automatic Bit_t misaligned(Mem_op_t op, logic [1:0] a);
    return (op inside {LH, LHU, SH} && a[0]) || (op inside {LW, SW} && a != 2'b00);
  endfunction
endpackage

// File: rtl/mem_access_align.sv
// mem_access_align: byte-enable and store-lane generation, load lane extract and extension
module mem_access_align
  import mem_access_pkg::*;
(
  input  Mem_op_t     op,
  input  logic [1:0]  lane,
  input  Word_t       sdata,
  input  Word_t       rdata,
  output logic [3:0]  be,
  output Word_t       wdata,
  output Word_t       ldata
);
  logic [7:0] b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{lane, 3'b000} +: 8];
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    be = op inside {LB, LBU, SB} ? 4'b0001 << lane :
         op inside {LH, LHU, SH} ? (lane[1] ? 4'b1100 : 4'b0011) :
         op == NOP ? 4'b0000 : 4'b1111;
    wdata = op == SB ? {4{sdata[7:0]}} : op == SH ? {2{sdata[15:0]}} : sdata;
    ldata = op == LB ? {{24{b[7]}}, b} :
            op == LBU ? {24'h0, b} :
            op == LH ? {{16{h[15]}}, h} :
            op == LHU ? {16'h0, h} : rdata;
  end
endmodule

// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage performing aligned loads/stores on a req/ack data bus
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  Mem_op_t     ex_mem_op,
  input  Word_t       ex_mem_addr,
  input  Word_t       ex_mem_sdata,
  input  Bit_t        ex_wreg_write,
  input  Reg_addr_t   ex_wreg_addr,
  input  Word_t       ex_wreg_data,
  output Bit_t        mem_wreg_write,
  output Reg_addr_t   mem_wreg_addr,
  output Word_t       mem_wreg_data,
  output Bit_t        stall_req,
  output Bit_t        exc_adel,
  output Bit_t        exc_ades,
  output Word_t       bad_vaddr,
  output Bit_t        bus_req,
  output Bit_t        bus_we,
  output Word_t       bus_addr,
  output logic [3:0]  bus_be,
  output Word_t       bus_wdata,
  input  Word_t       bus_rdata,
  input  Bit_t        bus_ack
);
  MEM_STATE_t state_q, state_d;
  Word_t load_buf_q, load_buf_d;
  Bit_t req_we_q;
  Word_t req_addr_q, req_wdata_q;
  logic [3:0] req_be_q;
  logic [3:0] be;
  Word_t wdata, ldata;
  Bit_t ld, st, mis, acc, hold;
  mem_access_align u_align (
    .op    (ex_mem_op),
    .lane  (ex_mem_addr[1:0]),
    .sdata (ex_mem_sdata),
    .rdata (bus_rdata),
    .be    (be),
    .wdata (wdata),
    .ldata (ldata)
  );
  always_comb begin
    ld = is_load(ex_mem_op);
    st = is_store(ex_mem_op);
    mis = misaligned(ex_mem_op, ex_mem_addr[1:0]);
    acc = (ld || st) && !mis && !flush;
    hold = state_q == WAIT || state_q == DRAIN;
    state_d = state_q;
    load_buf_d = load_buf_q;
    bus_req = DISABLE;
    stall_req = DISABLE;
    exc_adel = DISABLE;
    exc_ades = DISABLE;
    bad_vaddr = ex_mem_addr;
    mem_wreg_write = DISABLE;
    mem_wreg_data = ex_wreg_data;
    case (state_q)
      IDLE: begin
        exc_adel = ld && mis;
        exc_ades = st && mis;
        bus_req = acc;
        stall_req = acc;
        mem_wreg_write = ex_wreg_write && !ld && !st && !flush;
        if (acc) begin
          state_d = bus_ack ? DONE : WAIT;
          load_buf_d = bus_ack ? ldata : load_buf_q;
        end
      end
      WAIT: begin
        bus_req = ENABLE;
        stall_req = ENABLE;
        if (bus_ack) begin
          load_buf_d = ldata;
          state_d = flush ? IDLE : DONE;
        end else if (flush) begin
          state_d = DRAIN;
        end
      end
      DONE: begin
        mem_wreg_write = ld && ex_wreg_write && !flush;
        mem_wreg_data = ld ? load_buf_q : ex_wreg_data;
        state_d = IDLE;
      end
      default: begin
        bus_req = ENABLE;
        stall_req = ENABLE;
        state_d = bus_ack ? IDLE : DRAIN;
      end
    endcase
    if (rst) begin
      bus_req = DISABLE;
      stall_req = DISABLE;
      exc_adel = DISABLE;
      exc_ades = DISABLE;
      mem_wreg_write = DISABLE;
    end
    mem_wreg_addr = mem_wreg_write ? ex_wreg_addr : REG_ZERO;
    bus_we = bus_req && (hold ? req_we_q : st);
    bus_addr = hold ? req_addr_q : {ex_mem_addr[31:2], 2'b00};
    bus_be = bus_req ? (hold ? req_be_q : be) : 4'b0000;
    bus_wdata = hold ? req_wdata_q : wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      load_buf_q <= ZERO_WORD;
      req_we_q <= DISABLE;
      req_addr_q <= ZERO_WORD;
      req_be_q <= 4'b0000;
      req_wdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      load_buf_q <= load_buf_d;
      if (state_q == IDLE) begin
        req_we_q <= st;
        req_addr_q <= {ex_mem_addr[31:2], 2'b00};
        req_be_q <= be;
        req_wdata_q <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: randomized and directed checks of mem_access against a behavioural model
module tb_mem_access;
  import mem_access_pkg::*;
  logic clk = 0;
  logic rst = 1;
  logic flush = 0;
  Mem_op_t op_i = NOP;
  logic [31:0] addr_i = 0, sdata_i = 0, wd_i = 0, rdata_i = 0;
  logic ww_i = 0, ack_i = 0;
  logic [4:0] wa_i = 0;
  logic mw, stall, adel, ades, breq, bwe;
  logic [4:0] ma;
  logic [31:0] md, bad, baddr, bwdata;
  logic [3:0] bbe;
  int nchk = 0, nfail = 0;
  int stall_cnt, occ;
  logic [31:0] got_data, got_wdata, got_bad;
  logic [3:0] got_be;
  logic got_adel, got_ades;
  always #5 clk = ~clk;
  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_mem_op(op_i), .ex_mem_addr(addr_i), .ex_mem_sdata(sdata_i),
    .ex_wreg_write(ww_i), .ex_wreg_addr(wa_i), .ex_wreg_data(wd_i),
    .mem_wreg_write(mw), .mem_wreg_addr(ma), .mem_wreg_data(md),
    .stall_req(stall), .exc_adel(adel), .exc_ades(ades), .bad_vaddr(bad),
    .bus_req(breq), .bus_we(bwe), .bus_addr(baddr), .bus_be(bbe), .bus_wdata(bwdata),
    .bus_rdata(rdata_i), .bus_ack(ack_i)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic int sz_of(Mem_op_t op);
    case (op)
      LB, LBU, SB: return 1;
      LH, LHU, SH: return 2;
      LW, SW: return 4;
      default: return 0;
    endcase
  endfunction
  function automatic bit is_ld(Mem_op_t op);
    return op == LB || op == LBU || op == LH || op == LHU || op == LW;
  endfunction
  function automatic bit is_st(Mem_op_t op);
    return op == SB || op == SH || op == SW;
  endfunction
  function automatic logic [3:0] m_be(Mem_op_t op, logic [31:0] a);
    logic [3:0] r = 0;
    for (int i = 0; i < 4; i++) r[i] = i >= a % 4 && i < a % 4 + sz_of(op);
    return r;
  endfunction
  function automatic logic [31:0] m_wdata(Mem_op_t op, logic [31:0] sd);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sd[8*(i % sz_of(op)) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_load(Mem_op_t op, logic [31:0] a, logic [31:0] rd);
    longint v = longint'(rd >> (8 * (a % 4)));
    longint span = 64'd1 << (8 * sz_of(op));
    v = v % span;
    if ((op == LB || op == LH) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction
  task automatic run(input Mem_op_t op, input logic [31:0] a, input logic [31:0] sd,
                     input logic ww, input logic [4:0] wa, input logic [31:0] wd,
                     input int d, input logic [31:0] rd, input int fl);
    bit ld = is_ld(op), st = is_st(op);
    int s = sz_of(op);
    bit mis = s != 0 && a % s != 0;
    bit acc = (ld || st) && !mis && fl != 1;
    int n = acc ? d + 2 : 1;
    bit ew;
    op_i = op; addr_i = a; sdata_i = sd; ww_i = ww; wa_i = wa; wd_i = wd;
    stall_cnt = 0;
    occ = n;
    for (int c = 0; c < n; c++) begin
      ack_i = acc && c == d;
      rdata_i = ack_i ? rd : $urandom;
      flush = (fl == 1 && c == 0) || (fl == 2 && acc && c == n - 1);
      #4;
      if (stall) stall_cnt++;
      chk("stall_req", stall, acc && c <= d);
      chk("bus_req", breq, acc && c <= d);
      chk("exc_adel", adel, ld && mis);
      chk("exc_ades", ades, st && mis);
      if (mis) chk("bad_vaddr", bad, a);
      if (acc && c <= d) begin
        chk("bus_we", bwe, st);
        chk("bus_addr", baddr, a & 32'hFFFF_FFFC);
        chk("bus_be", bbe, m_be(op, a));
        if (st) chk("bus_wdata", bwdata, m_wdata(op, sd));
      end
      if (c == 0) begin
        got_be = bbe; got_wdata = bwdata; got_adel = adel; got_ades = ades; got_bad = bad;
      end
      if (c == n - 1) begin
        ew = acc ? (ld && ww && fl != 2) : (!ld && !st && ww && fl != 1);
        chk("mem_wreg_write", mw, ew);
        chk("mem_wreg_data", md, acc && ld ? m_load(op, a, rd) : wd);
        if (ew) chk("mem_wreg_addr", ma, wa);
        got_data = md;
      end else begin
        chk("mem_wreg_write_stalled", mw, 0);
      end
      @(posedge clk);
      #1;
    end
    ack_i = 0;
    flush = 0;
  endtask
  initial begin
    op_i = LW; addr_i = 32'h100; ww_i = 1;
    @(posedge clk);
    #4;
    chk("rst stall_req", stall, 0);
    chk("rst bus_req", breq, 0);
    chk("rst bus_we", bwe, 0);
    chk("rst bus_be", bbe, 0);
    chk("rst exc_adel", adel, 0);
    chk("rst mem_wreg_write", mw, 0);
    @(posedge clk);
    #1;
    rst = 0;
    run(LW, 32'h100, 0, 1, 5'd4, 32'h1111, 3, 32'hDEADBEEF, 0);
    chk("lw stall cycles", stall_cnt, 4);
    chk("lw data", got_data, 32'hDEADBEEF);
    run(LB, 32'h103, 0, 1, 5'd5, 0, 1, 32'h80FF_0000, 0);
    chk("lb data", got_data, 32'hFFFFFF80);
    run(LBU, 32'h103, 0, 1, 5'd5, 0, 0, 32'h80FF_0000, 0);
    chk("lbu data", got_data, 32'h00000080);
    run(LH, 32'h102, 0, 1, 5'd6, 0, 2, 32'h80FF_0000, 0);
    chk("lh data", got_data, 32'hFFFF80FF);
    run(SB, 32'h101, 32'h12345678, 1, 5'd7, 32'h9, 0, 0, 0);
    chk("sb be", got_be, 4'b0010);
    chk("sb wdata", got_wdata, 32'h78787878);
    chk("sb occupancy", occ, 2);
    run(LW, 32'h102, 0, 1, 5'd8, 32'h77, 0, 0, 0);
    chk("lw mis adel", got_adel, 1);
    chk("lw mis bad_vaddr", got_bad, 32'h102);
    run(SH, 32'h101, 32'hABCD, 0, 0, 0, 0, 0, 0);
    chk("sh mis ades", got_ades, 1);
    run(NOP, 32'h0, 0, 1, 5'd3, 32'd5, 0, 0, 0);
    chk("add data", got_data, 32'd5);
    op_i = LW; addr_i = 32'h100; ww_i = 1; wa_i = 5'd9;
    for (int c = 0; c < 5; c++) begin
      flush = c == 1;
      ack_i = c == 3;
      rdata_i = $urandom;
      if (c == 2) begin
        op_i = NOP; addr_i = 32'h200; wa_i = 5'd7; wd_i = 32'h55;
      end
      #4;
      chk("drain stall_req", stall, c < 4);
      chk("drain bus_req", breq, c < 4);
      if (c < 4) chk("drain bus_addr", baddr, 32'h100);
      if (c < 4) chk("drain bus_we", bwe, 0);
      chk("drain mem_wreg_write", mw, c == 4);
      if (c == 4) chk("drain pass data", md, 32'h55);
      @(posedge clk);
      #1;
    end
    ack_i = 0;
    flush = 0;
    op_i = LW; addr_i = 32'h300;
    @(posedge clk);
    #1;
    rst = 1;
    #4;
    chk("rst wait bus_req", breq, 0);
    chk("rst wait stall_req", stall, 0);
    @(posedge clk);
    #1;
    rst = 0;
    op_i = NOP;
    ww_i = 0;
    #4;
    chk("post rst stall_req", stall, 0);
    chk("post rst bus_req", breq, 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 300; k++) begin
      int r = $urandom_range(0, 19);
      run(Mem_op_t'($urandom_range(0, 8)), $urandom, $urandom, 1'($urandom), 5'($urandom),
          $urandom, $urandom_range(0, 3), $urandom, r == 0 ? 1 : r == 1 ? 2 : 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end
endmodule
